// File: rtl/lcr580_uart_pkg.sv
// lcr580_uart shared definitions: register offsets, status/ctrl bit
// positions and the TX/RX engine state encodings.
package lcr580_uart_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_LVL  = 2'd3;

  localparam int ST_RXNE = 0;
  localparam int ST_TXNF = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_OVR  = 3;
  localparam int ST_FERR = 4;

  localparam int CT_RXIE = 0;
  localparam int CT_TXIE = 1;
  localparam int CT_LPBK = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/lcr580_uart_fifo.sv
// lcr580_uart byte FIFO: DEPTH entries, wrap-bit pointers, head visible
// combinationally; a push on a full FIFO lands only if a pop shares the edge.
module lcr580_uart_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level   = wptr - rptr;
  assign rdata   = mem[rptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lcr580_uart.sv
// lcr580_uart: port-mapped 8N1 UART on the LCR580 I/O bus.
// Optional build macro LCR580_UART_LOOPBACK_EN enables ctrl.lpbk.
module lcr580_uart
  import lcr580_uart_pkg::*;
#(
  parameter logic [7:0]  BASE  = 8'h10,
  parameter logic [15:0] DIV   = 16'd434,
  parameter int          DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] port_addr,
  input  logic [7:0] port_wdata,
  input  logic       port_we,
  input  logic       port_rd,
  output logic [7:0] port_rdata,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);

  localparam int          LW   = $clog2(DEPTH) + 1;
  localparam logic [15:0] TBIT = DIV - 16'd1;
  localparam logic [15:0] HALF = (DIV >> 1) - 16'd1;
`ifdef LCR580_UART_LOOPBACK_EN
  localparam logic [2:0]  CMSK = 3'b111;
`else
  localparam logic [2:0]  CMSK = 3'b011;
`endif

  logic [7:0]    off;
  logic [1:0]    reg_sel;
  logic          hit;
  logic          wr;
  logic          rd;
  logic          tx_push;
  logic          rx_pop;
  logic [2:0]    ctrl;
  logic          ovr;
  logic          ferr;
  logic          tx_busy;

  logic [7:0]    txf_rdata;
  logic          txf_full;
  logic          txf_empty;
  logic [LW-1:0] txf_level;
  logic [7:0]    rxf_rdata;
  logic          rxf_full;
  logic          rxf_empty;
  logic [LW-1:0] rxf_level;

  tx_state_t     tx_st;
  tx_state_t     tx_nx;
  logic [15:0]   tx_tmr;
  logic [2:0]    tx_bitn;
  logic [7:0]    tx_sh;
  logic          tx_tick;
  logic          tx_pop;
  logic          tx_bit;

  rx_state_t     rx_st;
  rx_state_t     rx_nx;
  logic [15:0]   rx_tmr;
  logic [2:0]    rx_bitn;
  logic [7:0]    rx_sh;
  logic          rx_tick;
  logic          rx_s1;
  logic          rx_s2;
  logic          rx_line;
  logic          rx_prev;
  logic          rx_store;
  logic          unused;

  // Offsets BASE..BASE+3 are the only ones with bits [7:2] clear.
  assign off     = port_addr - BASE;
  assign hit     = (off[7:2] == 6'd0);
  assign reg_sel = off[1:0];
  assign wr      = ce & port_we & hit;
  assign rd      = ce & port_rd & ~port_we & hit;
  assign tx_push = wr & (reg_sel == REG_DATA);
  assign rx_pop  = rd & (reg_sel == REG_DATA);
  assign unused  = ^{port_wdata[7:3], txf_level};

  lcr580_uart_fifo #(.DEPTH(DEPTH)) u_txf (
    .clock (clock),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (port_wdata),
    .rdata (txf_rdata),
    .full  (txf_full),
    .empty (txf_empty),
    .level (txf_level)
  );

  lcr580_uart_fifo #(.DEPTH(DEPTH)) u_rxf (
    .clock (clock),
    .reset (reset),
    .push  (rx_store),
    .pop   (rx_pop),
    .wdata (rx_sh),
    .rdata (rxf_rdata),
    .full  (rxf_full),
    .empty (rxf_empty),
    .level (rxf_level)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (wr && reg_sel == REG_CTRL) ctrl <= port_wdata[2:0] & CMSK;
      ovr  <= (ovr & ~(wr && reg_sel == REG_STAT)) |
              (rx_store & rxf_full & ~rx_pop);
      ferr <= (ferr & ~(wr && reg_sel == REG_STAT)) |
              (rx_store & ~rx_line);
    end
  end

  always_comb begin
    port_rdata = 8'h00;
    if (port_rd && hit) begin
      unique case (reg_sel)
        REG_DATA: port_rdata = rxf_empty ? 8'h00 : rxf_rdata;
        REG_STAT: port_rdata = {3'b000, ferr, ovr, tx_busy,
                                ~txf_full, ~rxf_empty};
        REG_CTRL: port_rdata = {5'b00000, ctrl};
        REG_LVL:  port_rdata = 8'(rxf_level);
      endcase
    end
  end

  assign tx_busy = (tx_st != TX_IDLE) | ~txf_empty;
  assign irq     = (ctrl[CT_RXIE] & ~rxf_empty) |
                   (ctrl[CT_TXIE] & ~tx_busy);

  // TX engine
  assign tx_tick = (tx_tmr == 16'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_st   <= TX_IDLE;
      tx_tmr  <= '0;
      tx_bitn <= '0;
      tx_sh   <= '0;
    end else begin
      tx_st <= tx_nx;
      if (tx_st == TX_IDLE || tx_tick) tx_tmr <= TBIT;
      else                             tx_tmr <= tx_tmr - 16'd1;
      if (tx_st != TX_DATA) tx_bitn <= '0;
      else if (tx_tick)     tx_bitn <= tx_bitn + 3'd1;
      if (tx_pop)                        tx_sh <= txf_rdata;
      else if (tx_st == TX_DATA && tx_tick) tx_sh <= tx_sh >> 1;
    end
  end

  always_comb begin
    tx_nx  = tx_st;
    tx_pop = 1'b0;
    unique case (tx_st)
      TX_IDLE: if (!txf_empty) begin
        tx_nx  = TX_START;
        tx_pop = 1'b1;
      end
      TX_START: if (tx_tick) tx_nx = TX_DATA;
      TX_DATA: if (tx_tick && tx_bitn == 3'd7) tx_nx = TX_STOP;
      TX_STOP: if (tx_tick) begin
        tx_nx  = txf_empty ? TX_IDLE : TX_START;
        tx_pop = ~txf_empty;
      end
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    unique case (tx_st)
      TX_IDLE:  tx_bit = 1'b1;
      TX_START: tx_bit = 1'b0;
      TX_DATA:  tx_bit = tx_sh[0];
      TX_STOP:  tx_bit = 1'b1;
    endcase
  end

`ifdef LCR580_UART_LOOPBACK_EN
  assign txd     = ctrl[CT_LPBK] | tx_bit;
  assign rx_line = ctrl[CT_LPBK] ? tx_bit : rx_s2;
`else
  assign txd     = tx_bit;
  assign rx_line = rx_s2;
`endif

  // RX engine
  assign rx_tick = (rx_tmr == 16'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= RX_IDLE;
      rx_tmr  <= '0;
      rx_bitn <= '0;
      rx_sh   <= '0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_line;
      rx_st   <= rx_nx;
      if (rx_st == RX_IDLE) rx_tmr <= HALF;
      else if (rx_tick)     rx_tmr <= TBIT;
      else                  rx_tmr <= rx_tmr - 16'd1;
      if (rx_st != RX_DATA) rx_bitn <= '0;
      else if (rx_tick)     rx_bitn <= rx_bitn + 3'd1;
      if (rx_st == RX_DATA && rx_tick) rx_sh <= {rx_line, rx_sh[7:1]};
    end
  end

  always_comb begin
    rx_nx = rx_st;
    unique case (rx_st)
      RX_IDLE:  if (rx_prev && !rx_line) rx_nx = RX_START;
      RX_START: if (rx_tick) rx_nx = rx_line ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bitn == 3'd7) rx_nx = RX_STOP;
      RX_STOP:  if (rx_tick) rx_nx = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_store = (rx_st == RX_STOP) && rx_tick;
  end

endmodule

// File: tb/tb_lcr580_uart.sv
// Self-checking bench for lcr580_uart (DIV=4, BASE=8'h10, DEPTH=8).
// Scoreboard queues hold the bytes expected on txd and from the RX FIFO.
module tb_lcr580_uart;

  localparam int DIV   = 4;
  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b1;
  logic [7:0] port_addr = 8'h00;
  logic [7:0] port_wdata = 8'h00;
  logic       port_we = 1'b0;
  logic       port_rd = 1'b0;
  logic [7:0] port_rdata;
  logic       rxd = 1'b1;
  logic       txd;
  logic       irq;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         exp_ovr = 1'b0;
  bit         exp_ferr = 1'b0;

  always #5 clock = ~clock;

  lcr580_uart #(
    .BASE  (8'h10),
    .DIV   (16'd4),
    .DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ce         (ce),
    .port_addr  (port_addr),
    .port_wdata (port_wdata),
    .port_we    (port_we),
    .port_rd    (port_rd),
    .port_rdata (port_rdata),
    .rxd        (rxd),
    .txd        (txd),
    .irq        (irq)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_status(input bit busy);
    return {3'b000, exp_ferr, exp_ovr, busy, 1'b1, rx_q.size() != 0};
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    port_addr  = a;
    port_wdata = d;
    port_we    = 1'b1;
    @(negedge clock);
    port_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clock);
    port_addr = a;
    port_rd   = 1'b1;
    #1 d = port_rdata;
    @(negedge clock);
    port_rd   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else exp_ovr = 1'b1;
    if (!stop) exp_ferr = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (DIV) @(negedge clock);
    end
    rxd = 1'b1;
    repeat (DIV) @(negedge clock);
  endtask

  task automatic tx_capture(output logic [9:0] bits, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    while (txd !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) to = 1'b1;
    bits[0] = txd;
    for (int k = 1; k < 10; k++) begin
      repeat (DIV) @(negedge clock);
      bits[k] = txd;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_chk++;
    if (txd !== 1'b1 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pins: txd=%b irq=%b required 1 0", txd, irq);
    end
    reset = 1'b0;
    bus_read(8'h11, d);
    n_chk++;
    if (d !== 8'h02) begin
      n_fail++;
      $display("FAIL reset_status: got %h required 02", d);
    end
    bus_read(8'h12, d);
    n_chk++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h required 00", d);
    end
    bus_read(8'h13, d);
    n_chk++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_level: got %h required 00", d);
    end
    bus_read(8'h10, d);
    n_chk++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL empty_pop: got %h required 00", d);
    end
    bus_read(8'h20, d);
    n_chk++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL no_hit_read: got %h required 00", d);
    end
  endtask

  task automatic test_tx();
    logic [7:0] d;
    logic [7:0] e;
    logic [9:0] bits;
    bit         to;
    tx_q.push_back(8'hA5);
    bus_write(8'h10, 8'hA5);
    bus_read(8'h11, d);
    n_chk++;
    if (d !== exp_status(1'b1)) begin
      n_fail++;
      $display("FAIL tx_busy_start: got %h required %h", d, exp_status(1'b1));
    end
    tx_capture(bits, to);
    e = tx_q.pop_front();
    n_chk++;
    if (to || bits !== {1'b1, e, 1'b0}) begin
      n_fail++;
      $display("FAIL tx_frame: got %b timeout=%0d required %b",
               bits, to, {1'b1, e, 1'b0});
    end
    bus_read(8'h11, d);
    n_chk++;
    if (d !== exp_status(1'b1)) begin
      n_fail++;
      $display("FAIL tx_busy_stop: got %h required %h", d, exp_status(1'b1));
    end
    repeat (3) @(negedge clock);
    bus_read(8'h11, d);
    n_chk++;
    if (d !== exp_status(1'b0)) begin
      n_fail++;
      $display("FAIL tx_idle: got %h required %h", d, exp_status(1'b0));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [9:0] bits;
    bit         to;
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'hC3);
    bus_write(8'h10, 8'h3C);
    bus_write(8'h10, 8'hC3);
    for (int f = 0; f < 2; f++) begin
      tx_capture(bits, to);
      e = tx_q.pop_front();
      n_chk++;
      if (to || bits !== {1'b1, e, 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_frame%0d: got %b timeout=%0d required %b",
                 f, bits, to, {1'b1, e, 1'b0});
      end
    end
    repeat (6) @(negedge clock);
  endtask

  task automatic test_rx();
    logic [7:0] d;
    logic [7:0] e;
    send_byte(8'h3C, 1'b1);
    bus_read(8'h11, d);
    n_chk++;
    if (d !== exp_status(1'b0)) begin
      n_fail++;
      $display("FAIL rx_status: got %h required %h", d, exp_status(1'b0));
    end
    bus_read(8'h10, d);
    e = rx_q.pop_front();
    n_chk++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL rx_data: got %h required %h", d, e);
    end
    bus_read(8'h11, d);
    n_chk++;
    if (d !== 8'h02) begin
      n_fail++;
      $display("FAIL rx_status_empty: got %h required 02", d);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    logic [7:0] e;
    for (int i = 0; i < 9; i++) send_byte(8'h40 + 8'(i * 7), 1'b1);
    bus_read(8'h13, d);
    n_chk++;
    if (d !== 8'(rx_q.size())) begin
      n_fail++;
      $display("FAIL ovr_level: got %h required %h", d, 8'(rx_q.size()));
    end
    bus_read(8'h11, d);
    n_chk++;
    if (d !== exp_status(1'b0)) begin
      n_fail++;
      $display("FAIL ovr_set: got %h required %h", d, exp_status(1'b0));
    end
    bus_write(8'h11, 8'hFF);
    exp_ovr = 1'b0;
    bus_read(8'h11, d);
    n_chk++;
    if (d !== exp_status(1'b0)) begin
      n_fail++;
      $display("FAIL ovr_clear: got %h required %h", d, exp_status(1'b0));
    end
    while (rx_q.size() != 0) begin
      e = rx_q.pop_front();
      bus_read(8'h10, d);
      n_chk++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL ovr_pop: got %h required %h", d, e);
      end
    end
    bus_read(8'h13, d);
    n_chk++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL ovr_drain: got %h required 00", d);
    end
  endtask

  task automatic test_ferr_ce();
    logic [7:0] d;
    logic [7:0] e;
    send_byte(8'hE7, 1'b0);
    bus_read(8'h11, d);
    n_chk++;
    if (d !== exp_status(1'b0)) begin
      n_fail++;
      $display("FAIL ferr_set: got %h required %h", d, exp_status(1'b0));
    end
    ce = 1'b0;
    bus_read(8'h10, d);
    bus_write(8'h10, 8'h55);
    ce = 1'b1;
    bus_read(8'h13, d);
    n_chk++;
    if (d !== 8'(rx_q.size())) begin
      n_fail++;
      $display("FAIL ce_no_pop: got %h required %h", d, 8'(rx_q.size()));
    end
    bus_read(8'h11, d);
    n_chk++;
    if (d !== exp_status(1'b0)) begin
      n_fail++;
      $display("FAIL ce_no_push: got %h required %h", d, exp_status(1'b0));
    end
    bus_write(8'h11, 8'h00);
    exp_ferr = 1'b0;
    e = rx_q.pop_front();
    bus_read(8'h10, d);
    n_chk++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL ferr_byte: got %h required %h", d, e);
    end
  endtask

  task automatic test_irq();
    logic [7:0] d;
    logic [7:0] e;
    bus_write(8'h12, 8'h01);
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_rx_empty: got %b required 0", irq);
    end
    send_byte(8'h96, 1'b1);
    n_chk++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_rx_data: got %b required 1", irq);
    end
    e = rx_q.pop_front();
    bus_read(8'h10, d);
    n_chk++;
    if (d !== e || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_rx_pop: data %h irq %b required %h 0", d, irq, e);
    end
    bus_write(8'h12, 8'h02);
    n_chk++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_txe: got %b required 1", irq);
    end
    bus_write(8'h12, 8'h00);
    n_chk++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_off: got %b required 0", irq);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int         n;
    bus_write(8'h10, 8'h81);
    n = 0;
    while (txd !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    rxd = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    n_chk++;
    if (txd !== 1'b1 || n >= 100) begin
      n_fail++;
      $display("FAIL reset_midframe_txd: got %b required 1 (wait %0d)", txd, n);
    end
    rxd = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (DIV * 12) @(negedge clock);
    bus_read(8'h11, d);
    n_chk++;
    if (d !== 8'h02) begin
      n_fail++;
      $display("FAIL reset_midframe_status: got %h required 02", d);
    end
    bus_read(8'h13, d);
    n_chk++;
    if (d !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_midframe_rx: got %h required 00", d);
    end
  endtask

`ifdef LCR580_UART_LOOPBACK_EN
  task automatic test_loopback();
    logic [7:0] d;
    logic [7:0] e;
    bit         low_seen;
    low_seen = 1'b0;
    bus_write(8'h12, 8'h04);
    rx_q.push_back(8'h5A);
    bus_write(8'h10, 8'h5A);
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (txd !== 1'b1) low_seen = 1'b1;
    end
    n_chk++;
    if (low_seen) begin
      n_fail++;
      $display("FAIL lpbk_txd: pin left 1 during loopback, required held 1");
    end
    e = rx_q.pop_front();
    bus_read(8'h10, d);
    n_chk++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL lpbk_data: got %h required %h", d, e);
    end
    bus_write(8'h12, 8'h00);
  endtask
`endif

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx();
    test_overrun();
    test_ferr_ce();
    test_irq();
`ifdef LCR580_UART_LOOPBACK_EN
    test_loopback();
`endif
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
